dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (256 x 32-bit, async read, sync write) between the pipeline MEM stage and the debug unit's memory-dump sequencer.
- The pipeline owns the port by default. A debug dump request stalls the pipeline, reads DUMP_WORDS words sequentially and streams them out over a valid/ready handshake, then returns the port to the pipeline.
- Sits between the MEM stage and the RAM instance; its stall output ORs into the pipeline stall network.

Parameters:
- NB_DATA, 32, data word width.
- NB_ADDR, 8, RAM address width.
- DUMP_WORDS, 256, words per dump; 1 to 2^NB_ADDR; dump covers addresses 0 to DUMP_WORDS-1.

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_pipe_we  in  1  MEM-stage store request.
- i_pipe_addr  in  NB_ADDR  MEM-stage address.
- i_pipe_wdata  in  NB_DATA  MEM-stage store data.
- o_pipe_rdata  out  NB_DATA  read data to MEM stage; equals i_mem_rdata.
- o_pipe_stall  out  1  pipeline must hold while high.
- i_dbg_start  in  1  dump request pulse.
- i_dbg_ready  in  1  debug sink accepts a word.
- o_dbg_valid  out  1  o_dbg_data/o_dbg_addr valid.
- o_dbg_data  out  NB_DATA  dumped word.
- o_dbg_addr  out  NB_ADDR  address of dumped word.
- o_dbg_done  out  1  one-cycle pulse when a dump completes.
- o_busy  out  1  dump in progress.
- o_mem_we  out  1  RAM write enable.
- o_mem_addr  out  NB_ADDR  RAM address.
- o_mem_wdata  out  NB_DATA  RAM write data.
- i_mem_rdata  in  NB_DATA  RAM async read data.

Behaviour:
- Clock and reset: single clock clk. i_rst is synchronous, active-high.
- Reset: state = IDLE, counter = 0, o_dbg_valid = 0, o_dbg_data = 0, o_dbg_addr = 0, o_dbg_done = 0. Reset mid-dump aborts immediately with no done pulse; the port returns to the pipeline the next cycle.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - Mux selects the pipeline: o_mem_we = i_pipe_we, o_mem_addr = i_pipe_addr, o_mem_wdata = i_pipe_wdata.
  - o_pipe_stall = 0, o_busy = 0.
  - If i_dbg_start = 1: counter <= 0, go to READ. A pipeline store presented in the start cycle still commits in that cycle.
- READ:
  - o_mem_addr = counter, o_mem_we = 0.
  - o_dbg_data <= i_mem_rdata, o_dbg_addr <= counter, o_dbg_valid <= 1, go to SEND.
- SEND:
  - o_dbg_valid held; data and address stable until the handshake.
  - On i_dbg_ready = 1 (handshake): o_dbg_valid <= 0. If counter == DUMP_WORDS-1, go to DONE; else counter <= counter+1, go to READ.
  - With ready low, SEND waits indefinitely.
- DONE:
  - o_dbg_done = 1 for exactly this cycle; go to IDLE.
- Outside IDLE:
  - o_pipe_stall = 1, o_busy = 1, o_mem_we = 0. Pipeline stores are dropped; the pipeline is frozen by the stall.
  - i_dbg_start is ignored.
- Timing:
  - Stall rises the cycle after the start pulse and falls the cycle after DONE.
  - With ready tied high: 2 cycles per word; total stall = 2*DUMP_WORDS + 1 cycles.
- Counter:
  - Width NB_ADDR; never wraps within a dump.
  - For DUMP_WORDS = 256, the last address 255 is detected by compare, not by overflow.
- o_pipe_rdata = i_mem_rdata in all states; its content is meaningless while stalled.
- Outputs: o_pipe_stall, o_busy, o_dbg_done and the RAM mux are decoded combinationally from state only (no input-to-output paths except the IDLE mux). o_dbg_valid, o_dbg_data and o_dbg_addr are registered.

Test Plan:
- Reset, then pipeline store: i_pipe_we=1, addr 0x10, wdata 0xDEADBEEF in IDLE -> o_mem_we=1 same cycle; a later read at 0x10 returns 0xDEADBEEF; o_pipe_stall=0 throughout.
- Full dump, ready held high, RAM preloaded with mem[a]=a*4 -> 256 beats with o_dbg_addr 0..255, o_dbg_data 0..1020; o_dbg_done pulses once; o_pipe_stall high exactly 513 cycles.
- Backpressure: ready low for 5 cycles during beat at addr 3 -> data 12 and addr 3 stay stable; no skipped or duplicated address; done still after addr 255.
- Simultaneous store and start: i_pipe_we=1 at addr 7, data 0x55 in the i_dbg_start cycle -> store commits; dump beat 7 shows 0x55. A store attempted during the dump -> o_mem_we stays 0 and RAM is unchanged.
- Start while busy: second i_dbg_start pulse at beat 50 -> ignored; exactly one dump and one done pulse.
- Reset mid-dump at beat 100 -> next cycle stall=0, valid=0, busy=0, no done pulse; a subsequent start restarts from addr 0.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
//   Bundles the three buses around the data-memory port arbiter:
//     - pipeline MEM stage : i_pipe_we/addr/wdata in, o_pipe_rdata/stall out
//     - debug dump stream  : i_dbg_start/ready in, o_dbg_valid/data/addr/done
//                            and o_busy out
//     - RAM port           : o_mem_we/addr/wdata out, i_mem_rdata in
//   Signal names keep the arbiter-relative i_/o_ direction prefixes.
//   modport master : the arbiter itself.
//   modport slave  : the surrounding pipeline, debug unit and RAM.
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
);
    logic               i_pipe_we;
    logic [NB_ADDR-1:0] i_pipe_addr;
    logic [NB_DATA-1:0] i_pipe_wdata;
    logic [NB_DATA-1:0] o_pipe_rdata;
    logic               o_pipe_stall;

    logic               i_dbg_start;
    logic               i_dbg_ready;
    logic               o_dbg_valid;
    logic [NB_DATA-1:0] o_dbg_data;
    logic [NB_ADDR-1:0] o_dbg_addr;
    logic               o_dbg_done;
    logic               o_busy;

    logic               o_mem_we;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_DATA-1:0] o_mem_wdata;
    logic [NB_DATA-1:0] i_mem_rdata;

    modport master (
        input  i_pipe_we, i_pipe_addr, i_pipe_wdata,
        input  i_dbg_start, i_dbg_ready,
        input  i_mem_rdata,
        output o_pipe_rdata, o_pipe_stall,
        output o_dbg_valid, o_dbg_data, o_dbg_addr, o_dbg_done, o_busy,
        output o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport slave (
        output i_pipe_we, i_pipe_addr, i_pipe_wdata,
        output i_dbg_start, i_dbg_ready,
        output i_mem_rdata,
        input  o_pipe_rdata, o_pipe_stall,
        input  o_dbg_valid, o_dbg_data, o_dbg_addr, o_dbg_done, o_busy,
        input  o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single data-memory port (async read, sync write) between the
//   pipeline MEM stage and the debug memory-dump sequencer. The pipeline owns
//   the port in IDLE. A dump request stalls the pipeline, walks addresses
//   0..DUMP_WORDS-1, streams each word over a valid/ready handshake, pulses
//   o_dbg_done, then hands the port back.
//
// Ports:
//   clk    : clock
//   i_rst  : synchronous active-high reset
//   bus    : dmem_port_arbiter_if.master (pipeline, debug stream, RAM port)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 8,
    parameter int DUMP_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  i_rst,
    dmem_port_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last address is found by compare so DUMP_WORDS = 2^NB_ADDR never needs
    // the counter to overflow.
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DUMP_WORDS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [NB_ADDR-1:0] cnt;
    logic [NB_ADDR-1:0] cnt_nxt;
    logic               dbg_valid;
    logic [NB_DATA-1:0] dbg_data;
    logic [NB_ADDR-1:0] dbg_addr;
    logic               idle;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dbg_valid <= 1'b0;
            dbg_data  <= '0;
            dbg_addr  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == READ) begin
                // Capture the async RAM word; it is held until accepted.
                dbg_data  <= bus.i_mem_rdata;
                dbg_addr  <= cnt;
                dbg_valid <= 1'b1;
            end else if (state == SEND && bus.i_dbg_ready) begin
                dbg_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.i_dbg_start) begin
                    cnt_nxt   = '0;
                    state_nxt = READ;
                end
            end
            READ: state_nxt = SEND;
            SEND: begin
                if (bus.i_dbg_ready) begin
                    if (cnt == LAST_ADDR) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port ownership is decoded from state alone; only the IDLE pass-through
    // carries pipeline inputs to the RAM.
    assign idle             = (state == IDLE);
    assign bus.o_mem_we     = idle ? bus.i_pipe_we    : 1'b0;
    assign bus.o_mem_addr   = idle ? bus.i_pipe_addr  : cnt;
    assign bus.o_mem_wdata  = idle ? bus.i_pipe_wdata : '0;
    assign bus.o_pipe_rdata = bus.i_mem_rdata;
    assign bus.o_pipe_stall = ~idle;
    assign bus.o_busy       = ~idle;
    assign bus.o_dbg_done   = (state == DONE);
    assign bus.o_dbg_valid  = dbg_valid;
    assign bus.o_dbg_data   = dbg_data;
    assign bus.o_dbg_addr   = dbg_addr;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Directed bench for dmem_port_arbiter with a behavioural 256 x 32 RAM
//   (async read, sync write). Expected dump contents come from ref_mem, a
//   bench-side copy of what was written into the RAM.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int NB_DATA    = 32;
    localparam int NB_ADDR    = 8;
    localparam int DUMP_WORDS = 256;

    logic clk = 1'b0;
    logic i_rst;
    logic do_preload;

    logic [NB_DATA-1:0] ram     [256];
    logic [NB_DATA-1:0] ref_mem [256];

    int total = 0;
    int bad   = 0;

    dmem_port_arbiter_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

    dmem_port_arbiter #(
        .NB_DATA   (NB_DATA),
        .NB_ADDR   (NB_ADDR),
        .DUMP_WORDS(DUMP_WORDS)
    ) dut (
        .clk  (clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.i_mem_rdata = ram[bus.o_mem_addr];

    always @(posedge clk) begin
        if (do_preload) begin
            for (int a = 0; a < 256; a++) ram[a] <= 32'(a * 4);
        end else if (bus.o_mem_we) begin
            ram[bus.o_mem_addr] <= bus.o_mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then follows the dump until the port returns to the
    // pipeline. Optional events keyed on handshake count: backpressure at a
    // given address, a second start pulse, a blocked store, a reset.
    task automatic run_dump(input int bp_addr, input int bp_len,
                            input int restart_beat, input int store_beat,
                            input int rst_beat,
                            output int beats, output int stalls,
                            output int busys, output int dones);
        int  exp_a = 0;
        int  hold  = 0;
        bit  ended = 0;
        beats = 0; stalls = 0; busys = 0; dones = 0;
        bus.i_dbg_start = 1'b1;
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.i_dbg_start = 1'b0;
            bus.i_pipe_we   = 1'b0;
            bus.i_dbg_ready = 1'b1;
            if (!bus.o_pipe_stall) begin
                ended = 1;
                break;
            end
            stalls++;
            if (bus.o_busy)     busys++;
            if (bus.o_dbg_done) dones++;
            if (bus.o_dbg_valid) begin
                if (int'(bus.o_dbg_addr) == bp_addr && hold < bp_len) begin
                    bus.i_dbg_ready = 1'b0;
                    hold++;
                    chk("hold_addr", bus.o_dbg_addr, exp_a);
                    chk("hold_data", bus.o_dbg_data, ref_mem[bp_addr]);
                end else begin
                    chk("beat_addr", bus.o_dbg_addr, exp_a);
                    chk("beat_data", bus.o_dbg_data, ref_mem[exp_a[7:0]]);
                    exp_a++;
                    beats++;
                    if (beats == restart_beat) bus.i_dbg_start = 1'b1;
                    if (beats == store_beat) begin
                        bus.i_pipe_we    = 1'b1;
                        bus.i_pipe_addr  = 8'h20;
                        bus.i_pipe_wdata = 32'h0000_0BAD;
                        #1;
                        chk("store_blocked_we", bus.o_mem_we, 1'b0);
                    end
                    if (beats == rst_beat) begin
                        i_rst = 1'b1;
                        tick();
                        i_rst = 1'b0;
                        chk("rst_stall", bus.o_pipe_stall, 1'b0);
                        chk("rst_valid", bus.o_dbg_valid, 1'b0);
                        chk("rst_busy",  bus.o_busy, 1'b0);
                        chk("rst_done",  bus.o_dbg_done, 1'b0);
                        ended = 1;
                        break;
                    end
                end
            end
            tick();
        end
        bus.i_dbg_ready = 1'b1;
        if (!ended) chk("dump_timeout", 1'b0, 1'b1);
    endtask

    int beats, stalls, busys, dones;

    initial begin
        i_rst            = 1'b1;
        do_preload       = 1'b0;
        bus.i_pipe_we    = 1'b0;
        bus.i_pipe_addr  = '0;
        bus.i_pipe_wdata = '0;
        bus.i_dbg_start  = 1'b0;
        bus.i_dbg_ready  = 1'b1;
        for (int a = 0; a < 256; a++) ram[a] = '0;
        repeat (3) tick();

        chk("reset_valid", bus.o_dbg_valid, 1'b0);
        chk("reset_data",  bus.o_dbg_data, 32'h0);
        chk("reset_addr",  bus.o_dbg_addr, 8'h0);
        chk("reset_done",  bus.o_dbg_done, 1'b0);
        chk("reset_stall", bus.o_pipe_stall, 1'b0);
        chk("reset_busy",  bus.o_busy, 1'b0);
        i_rst = 1'b0;

        // Pipeline store and read-back in IDLE.
        bus.i_pipe_we    = 1'b1;
        bus.i_pipe_addr  = 8'h10;
        bus.i_pipe_wdata = 32'hDEAD_BEEF;
        #1;
        chk("pipe_we_pass", bus.o_mem_we, 1'b1);
        chk("pipe_addr_pass", bus.o_mem_addr, 8'h10);
        chk("pipe_stall_st", bus.o_pipe_stall, 1'b0);
        tick();
        bus.i_pipe_we   = 1'b0;
        bus.i_pipe_addr = 8'h10;
        #1;
        chk("pipe_readback", bus.o_pipe_rdata, 32'hDEAD_BEEF);
        chk("pipe_stall_rd", bus.o_pipe_stall, 1'b0);

        // Preload mem[a] = a*4.
        do_preload = 1'b1;
        tick();
        do_preload = 1'b0;
        for (int a = 0; a < 256; a++) ref_mem[a] = 32'(a * 4);

        // Full dump, ready high.
        run_dump(-1, 0, -1, -1, -1, beats, stalls, busys, dones);
        chk("full_beats", beats, 256);
        chk("full_stall", stalls, 513);
        chk("full_busy",  busys, 513);
        chk("full_done",  dones, 1);

        // Backpressure: 5 cycles of ready low at address 3.
        run_dump(3, 5, -1, -1, -1, beats, stalls, busys, dones);
        chk("bp_beats", beats, 256);
        chk("bp_stall", stalls, 518);
        chk("bp_done",  dones, 1);

        // Store in the start cycle commits; store during dump is dropped.
        bus.i_pipe_we    = 1'b1;
        bus.i_pipe_addr  = 8'h07;
        bus.i_pipe_wdata = 32'h55;
        #1;
        chk("start_store_we", bus.o_mem_we, 1'b1);
        ref_mem[7] = 32'h55;
        run_dump(-1, 0, -1, 20, -1, beats, stalls, busys, dones);
        chk("st_beats", beats, 256);
        chk("st_done",  dones, 1);
        bus.i_pipe_addr = 8'h20;
        #1;
        chk("ram_unchanged", bus.o_pipe_rdata, 32'h80);

        // Second start at beat 50 is ignored.
        run_dump(-1, 0, 50, -1, -1, beats, stalls, busys, dones);
        chk("rs_beats", beats, 256);
        chk("rs_stall", stalls, 513);
        chk("rs_done",  dones, 1);
        tick();
        chk("rs_idle_after", bus.o_pipe_stall, 1'b0);

        // Reset at beat 100, then a fresh dump from address 0.
        run_dump(-1, 0, -1, -1, 100, beats, stalls, busys, dones);
        chk("rst_beats", beats, 100);
        chk("rst_no_done", dones, 0);
        run_dump(-1, 0, -1, -1, -1, beats, stalls, busys, dones);
        chk("post_rst_beats", beats, 256);
        chk("post_rst_stall", stalls, 513);
        chk("post_rst_done",  dones, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
